// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one multi-cycle GCD engine between N requesters.
// Optional WAIT-state timeout abort is built when GCD_ARB_TIMEOUT_EN is defined.
module gcd_arbiter #(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   i_req,
   input  logic [N*W-1:0] i_aIn,
   input  logic [N*W-1:0] i_bIn,
   output logic [N-1:0]   o_gnt,
   output logic [N-1:0]   o_rspValid,
   output logic [W-1:0]   o_result,
   output logic           o_err,
   output logic           o_busy,
   output logic           o_gcdStart,
   output logic [W-1:0]   o_gcdA,
   output logic [W-1:0]   o_gcdB,
   input  logic           i_gcdDone,
   input  logic [W-1:0]   i_gcdResult,
   output logic           o_gcdAbort
);

   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t         r_state, w_stateNext;
   logic [IW-1:0]  r_idx, w_idxNext;
   logic [IW-1:0]  r_ptr, w_ptrNext;
   logic [W-1:0]   r_gcdA, w_gcdANext;
   logic [W-1:0]   r_gcdB, w_gcdBNext;
   logic [N-1:0]   r_gnt, w_gntNext;
   logic [N-1:0]   r_rspValid, w_rspValidNext;
   logic [W-1:0]   r_result, w_resultNext;
   logic           r_busy, w_busyNext;
   logic           r_gcdStart, w_gcdStartNext;
   logic           w_found;
   logic [IW-1:0]  w_selIdx;
   logic [W-1:0]   w_selA;
   logic [W-1:0]   w_selB;

`ifdef GCD_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]  r_cnt, w_cntNext;
   logic           r_err, w_errNext;
   logic           r_gcdAbort, w_gcdAbortNext;
`endif

   function automatic logic [N-1:0] oneHot(input logic [IW-1:0] idx);
      return N'(1) << idx;
   endfunction

   // Scan downward so the requester closest to the pointer is the last (winning) hit.
   always_comb begin
      w_found  = 1'b0;
      w_selIdx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[(int'(r_ptr) + k) % N]) begin
            w_found  = 1'b1;
            w_selIdx = IW'((int'(r_ptr) + k) % N);
         end
      end
      w_selA = i_aIn[int'(w_selIdx)*W +: W];
      w_selB = i_bIn[int'(w_selIdx)*W +: W];
   end

   always_comb begin
      w_stateNext     = r_state;
      w_idxNext       = r_idx;
      w_ptrNext       = r_ptr;
      w_gcdANext      = r_gcdA;
      w_gcdBNext      = r_gcdB;
      w_gntNext       = '0;
      w_rspValidNext  = '0;
      w_resultNext    = '0;
      w_gcdStartNext  = 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      w_cntNext       = r_cnt;
      w_errNext       = 1'b0;
      w_gcdAbortNext  = 1'b0;
`endif
      unique case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_idxNext      = w_selIdx;
               w_gcdANext     = w_selA;
               w_gcdBNext     = w_selB;
               w_gntNext      = oneHot(w_selIdx);
               w_gcdStartNext = (w_selA != '0) && (w_selB != '0);
               w_stateNext    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // A zero operand makes the GCD the other operand, so the engine is skipped.
            if ((r_gcdA == '0) || (r_gcdB == '0)) begin
               w_rspValidNext = oneHot(r_idx);
               w_resultNext   = r_gcdA | r_gcdB;
               w_stateNext    = ST_RESP;
            end else begin
               w_stateNext = ST_WAIT;
`ifdef GCD_ARB_TIMEOUT_EN
               w_cntNext   = '0;
`endif
            end
         end
         ST_WAIT: begin
            if (i_gcdDone) begin
               w_rspValidNext = oneHot(r_idx);
               w_resultNext   = i_gcdResult;
               w_stateNext    = ST_RESP;
            end
`ifdef GCD_ARB_TIMEOUT_EN
            else if (r_cnt == CW'(TIMEOUT - 1)) begin
               w_rspValidNext = oneHot(r_idx);
               w_errNext      = 1'b1;
               w_gcdAbortNext = 1'b1;
               w_stateNext    = ST_RESP;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
`endif
         end
         ST_RESP: begin
            w_ptrNext   = (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
            w_stateNext = ST_IDLE;
         end
         default: w_stateNext = ST_IDLE;
      endcase
      w_busyNext = (w_stateNext != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_ptr      <= '0;
         r_gcdA     <= '0;
         r_gcdB     <= '0;
         r_gnt      <= '0;
         r_rspValid <= '0;
         r_result   <= '0;
         r_busy     <= 1'b0;
         r_gcdStart <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_idx      <= w_idxNext;
         r_ptr      <= w_ptrNext;
         r_gcdA     <= w_gcdANext;
         r_gcdB     <= w_gcdBNext;
         r_gnt      <= w_gntNext;
         r_rspValid <= w_rspValidNext;
         r_result   <= w_resultNext;
         r_busy     <= w_busyNext;
         r_gcdStart <= w_gcdStartNext;
      end
   end

`ifdef GCD_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_err      <= 1'b0;
         r_gcdAbort <= 1'b0;
      end else begin
         r_cnt      <= w_cntNext;
         r_err      <= w_errNext;
         r_gcdAbort <= w_gcdAbortNext;
      end
   end

   assign o_err      = r_err;
   assign o_gcdAbort = r_gcdAbort;
`else
   assign o_err      = 1'b0;
   assign o_gcdAbort = 1'b0;
`endif

   assign o_gnt      = r_gnt;
   assign o_rspValid = r_rspValid;
   assign o_result   = r_result;
   assign o_busy     = r_busy;
   assign o_gcdStart = r_gcdStart;
   assign o_gcdA     = r_gcdA;
   assign o_gcdB     = r_gcdB;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter: a round-robin service-order model predicts every grant
// and response, a stand-in GCD engine answers start pulses, and a monitor checks the outputs.
module tb_gcd_arbiter;

   localparam int N       = 4;
   localparam int W       = 8;
   localparam int TIMEOUT = 20;

   typedef struct {
      int           idx;
      logic [W-1:0] res;
      bit           bypass;
      bit           err;
   } rspEntry_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] aIn = '0;
   logic [N*W-1:0] bIn = '0;
   logic [N-1:0]   gnt;
   logic [N-1:0]   rspValid;
   logic [W-1:0]   result;
   logic           err;
   logic           busy;
   logic           gcdStart;
   logic [W-1:0]   gcdA;
   logic [W-1:0]   gcdB;
   logic           gcdDone = 1'b0;
   logic [W-1:0]   gcdResult = '0;
   logic           gcdAbort;

   int compareCount = 0;
   int failCount    = 0;
   int cycle        = 0;
   int modelPtr     = 0;
   int lastGntCycle = 0;
   int doneCycle    = 0;
   int fixedLat     = 0;
   bit engineHang   = 1'b0;
   int staleReqCount = 0;
   int staleServed   = 0;

   rspEntry_t expGnt[$];
   rspEntry_t expRsp[$];

   gcd_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (req),
      .i_aIn       (aIn),
      .i_bIn       (bIn),
      .o_gnt       (gnt),
      .o_rspValid  (rspValid),
      .o_result    (result),
      .o_err       (err),
      .o_busy      (busy),
      .o_gcdStart  (gcdStart),
      .o_gcdA      (gcdA),
      .o_gcdB      (gcdB),
      .i_gcdDone   (gcdDone),
      .i_gcdResult (gcdResult),
      .o_gcdAbort  (gcdAbort)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Euclid by remainder: the reference answer, independent of the engine's method.
   function automatic logic [W-1:0] refGcd(input logic [W-1:0] a, input logic [W-1:0] b);
      int x = int'(a);
      int y = int'(b);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return W'(x);
   endfunction

   function automatic logic [W-1:0] subtractGcd(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] x = a;
      logic [W-1:0] y = b;
      while (x != y) begin
         if (x > y) x = x - y;
         else       y = y - x;
      end
      return x;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cycle);
      end
   endtask

   // Stand-in engine: answers each start after a latency, can hang, or emit a stale done.
   initial begin
      bit           engBusy = 1'b0;
      bit           doneOn = 1'b0;
      int           left = 0;
      logic [W-1:0] engRes = '0;
      forever begin
         @(negedge clk);
         if (doneOn) begin
            gcdDone = 1'b0;
            doneOn  = 1'b0;
         end
         if (!rst_n) engBusy = 1'b0;
         if (staleReqCount != staleServed) begin
            gcdDone   = 1'b1;
            gcdResult = 8'hAA;
            doneOn    = 1'b1;
            staleServed++;
         end else if (engBusy && !engineHang) begin
            left--;
            if (left == 0) begin
               gcdDone   = 1'b1;
               gcdResult = engRes;
               doneCycle = cycle;
               doneOn    = 1'b1;
               engBusy   = 1'b0;
            end
         end
         if (rst_n && gcdStart) begin
            engBusy = 1'b1;
            left    = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 12));
            engRes  = subtractGcd(gcdA, gcdB);
         end
         if (gcdAbort) engBusy = 1'b0;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a grant or a response.
   initial begin
      rspEntry_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (gnt != '0) begin
               if (expGnt.size() == 0) begin
                  checkOutput("unexpectedGnt", 32'(gnt), 32'd0);
               end else begin
                  e = expGnt.pop_front();
                  checkOutput("gnt", 32'(gnt), 32'(1 << e.idx));
                  checkOutput("gcdStartAtGnt", 32'(gcdStart), 32'(!e.bypass));
                  checkOutput("busyAtGnt", 32'(busy), 32'd1);
                  lastGntCycle = cycle;
               end
            end else if (gcdStart) begin
               checkOutput("strayGcdStart", 32'(gcdStart), 32'd0);
            end
            if (rspValid != '0) begin
               if (expRsp.size() == 0) begin
                  checkOutput("unexpectedRsp", 32'(rspValid), 32'd0);
               end else begin
                  e = expRsp.pop_front();
                  checkOutput("rspValid", 32'(rspValid), 32'(1 << e.idx));
                  checkOutput("result", 32'(result), 32'(e.res));
                  checkOutput("err", 32'(err), 32'(e.err));
                  checkOutput("gcdAbortWithRsp", 32'(gcdAbort), 32'(e.err));
                  if (e.err)
                     checkOutput("timeoutLatency", 32'(cycle), 32'(lastGntCycle + TIMEOUT + 1));
                  else if (e.bypass)
                     checkOutput("bypassLatency", 32'(cycle), 32'(lastGntCycle + 1));
                  else
                     checkOutput("engineLatency", 32'(cycle), 32'(doneCycle + 1));
               end
            end else if (gcdAbort) begin
               checkOutput("strayGcdAbort", 32'(gcdAbort), 32'd0);
            end
         end
      end
   end

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      #1;
      checkOutput("rstGnt", 32'(gnt), 32'd0);
      checkOutput("rstRspValid", 32'(rspValid), 32'd0);
      checkOutput("rstResult", 32'(result), 32'd0);
      checkOutput("rstErr", 32'(err), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstGcdStart", 32'(gcdStart), 32'd0);
      checkOutput("rstGcdAbort", 32'(gcdAbort), 32'd0);
      checkOutput("rstGcdA", 32'(gcdA), 32'd0);
      checkOutput("rstGcdB", 32'(gcdB), 32'd0);
      expGnt.delete();
      expRsp.delete();
      modelPtr = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // All requesters in the mask are raised together while the arbiter is idle, so they are
   // served once each in circular order starting from the model pointer.
   task automatic applyStimulus(input logic [N-1:0] mask, input logic [N*W-1:0] aVec,
                                input logic [N*W-1:0] bVec, input bit expectTimeout);
      rspEntry_t e;
      int last = modelPtr;
      int i;
      int budget;
      for (int k = 0; k < N; k++) begin
         i = (modelPtr + k) % N;
         if (mask[i]) begin
            e.idx    = i;
            e.bypass = (aVec[i*W +: W] == '0) || (bVec[i*W +: W] == '0);
            e.err    = expectTimeout;
            e.res    = expectTimeout ? '0 : refGcd(aVec[i*W +: W], bVec[i*W +: W]);
            expGnt.push_back(e);
            expRsp.push_back(e);
            last = i;
         end
      end
      modelPtr = (last + 1) % N;
      @(negedge clk);
      aIn = aVec;
      bIn = bVec;
      req = mask;
      budget = 0;
      forever begin
         @(negedge clk);
         req = req & ~gnt;
         budget++;
         if (req == '0 && !busy && expRsp.size() == 0) break;
         if (budget > 2000) begin
            checkOutput("batchTimeout", 32'(expRsp.size()), 32'd0);
            break;
         end
      end
   endtask

   task automatic issueHanging(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      rspEntry_t e;
      int budget = 0;
      e.idx = idx; e.res = '0; e.bypass = 1'b0; e.err = 1'b0;
      expGnt.push_back(e);
      @(negedge clk);
      aIn[idx*W +: W] = a;
      bIn[idx*W +: W] = b;
      req[idx] = 1'b1;
      while (req != '0 && budget < 20) begin
         @(negedge clk);
         req = req & ~gnt;
         budget++;
      end
      checkOutput("hangGranted", 32'(req), 32'd0);
   endtask

   initial begin
      logic [N*W-1:0] av;
      logic [N*W-1:0] bv;
      logic [N-1:0]   m;

      doReset();

      fixedLat = 10;
      av = '0; bv = '0;
      av[1*W +: W] = 8'd48; bv[1*W +: W] = 8'd18;
      applyStimulus(4'b0010, av, bv, 1'b0);
      checkOutput("busyAfterSingle", 32'(busy), 32'd0);
      fixedLat = 0;

      av = {4{8'd12}}; bv = {4{8'd8}};
      applyStimulus(4'b1111, av, bv, 1'b0);
      applyStimulus(4'b1111, av, bv, 1'b0);

      av = '0; bv = '0;
      bv[2*W +: W] = 8'd35;
      applyStimulus(4'b0100, av, bv, 1'b0);
      bv = '0;
      applyStimulus(4'b0100, av, bv, 1'b0);

      av = {8'd30, 8'd21, 8'd20, 8'd77};
      bv = {8'd45, 8'd14, 8'd15, 8'd0};
      applyStimulus(4'b0100, av, bv, 1'b0);
      applyStimulus(4'b0101, av, bv, 1'b0);

      for (int n = 0; n < 40; n++) begin
         m = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            av[i*W +: W] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            bv[i*W +: W] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
         end
         applyStimulus(m, av, bv, 1'b0);
      end

      // Put the pointer at 3 so a surviving pointer after reset would grant requester 3 first.
      av = {4{8'd9}}; bv = {4{8'd6}};
      applyStimulus(4'b0100, av, bv, 1'b0);
      engineHang = 1'b1;
      issueHanging(1, 8'd48, 8'd18);
      repeat (3) @(negedge clk);
      checkOutput("busyInWait", 32'(busy), 32'd1);
      doReset();
      engineHang = 1'b0;
      staleReqCount++;
      repeat (5) @(negedge clk);
      checkOutput("busyAfterStaleDone", 32'(busy), 32'd0);
      av = {8'd27, 8'd5, 8'd5, 8'd36}; bv = {8'd18, 8'd5, 8'd5, 8'd24};
      applyStimulus(4'b1001, av, bv, 1'b0);

`ifdef GCD_ARB_TIMEOUT_EN
      engineHang = 1'b1;
      av = {4{8'd9}}; bv = {4{8'd6}};
      applyStimulus(4'b0100, av, bv, 1'b1);
      engineHang = 1'b0;
      applyStimulus(4'b0010, av, bv, 1'b0);
`else
      engineHang = 1'b1;
      issueHanging(2, 8'd9, 8'd6);
      for (int k = 0; k < 6; k++) begin
         repeat (50) @(negedge clk);
         checkOutput("busyHeldNoTimeout", 32'(busy), 32'd1);
      end
      doReset();
      engineHang = 1'b0;
      av = {4{8'd9}}; bv = {4{8'd6}};
      applyStimulus(4'b0100, av, bv, 1'b0);
`endif

      repeat (3) @(negedge clk);
      checkOutput("expRspDrained", 32'(expRsp.size()), 32'd0);
      checkOutput("expGntDrained", 32'(expGnt.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle GCD engine (subtract-and-compare datapath plus its Moore controller) between N requesters. It accepts an operand pair from one requester, issues a start pulse to the engine, waits for the engine's done, and returns the result tagged to the granted requester. It sits between the client blocks and the single GCD engine instance, so no client drives the engine directly.

## Interface
- N, 4, number of requesters (2..8)
- W, 8, operand/result width
- TIMEOUT, 255, max WAIT cycles before abort (used only with GCD_ARB_TIMEOUT_EN)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  N  per-requester request; held with operands until own gnt bit seen
- a_in  in  N*W  operand A, requester i at bits [i*W +: W]
- b_in  in  N*W  operand B, same packing
- gnt  out  N  one-hot, one-cycle pulse: operands of that requester captured
- rsp_valid  out  N  one-hot, one-cycle pulse: result valid for that requester
- result  out  W  GCD result, valid only while rsp_valid != 0
- err  out  1  pulses with rsp_valid on timeout abort
- busy  out  1  high in every state except IDLE
- gcd_start  out  1  one-cycle start pulse to engine
- gcd_a, gcd_b  out  W  operands to engine, stable from ISSUE through WAIT
- gcd_done  in  1  engine completion
- gcd_result  in  W  engine result, sampled when gcd_done=1 in WAIT
- gcd_abort  out  1  one-cycle engine abort on timeout

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs registered.
- IDLE: if req != 0, select first requesting index at or after ptr (wrapping mod N); latch index, a_in/b_in slice into gcd_a/gcd_b; go ISSUE. Else stay.
- ISSUE: gnt[idx]=1. If gcd_a==0 or gcd_b==0: bypass, result_reg = gcd_a | gcd_b, gcd_start=0, go RESP. Else gcd_start=1, go WAIT.
- WAIT: on gcd_done=1 capture gcd_result, go RESP. gcd_done outside WAIT ignored.
- RESP: rsp_valid[idx]=1, result driven; ptr <= (idx+1) mod N; go IDLE.
- Requester must drop req on the cycle after its gnt; req still high in IDLE is a new request.
- Requests arriving while busy wait; no queuing beyond req level.
- Reset (any state, any time): state IDLE, ptr=0, gnt=0, rsp_valid=0, result=0, err=0, busy=0, gcd_start=0, gcd_abort=0, gcd_a=gcd_b=0. Engine reset separately; an in-flight result is discarded.

## Timing
- req sampled in IDLE at cycle T; gnt and gcd_start at T+1; WAIT from T+2.
- gcd_done at cycle D (D >= T+2) -> rsp_valid at D+1; IDLE at D+2, next sample at D+2, next gnt at D+3.
- Zero bypass: gnt at T+1, rsp_valid at T+2.
- gcd_done in the same cycle as gcd_start is impossible (ISSUE ignores it).
- Minimum request-to-request spacing: 4 cycles (bypass), 5 cycles (engine path, 1-cycle engine).

## Configuration
- GCD_ARB_TIMEOUT_EN defined: W-agnostic counter cleared on entry to WAIT, increments each WAIT cycle; if it reaches TIMEOUT with gcd_done=0, gcd_abort pulses one cycle, RESP follows with result=0, err=1. gcd_done on the same cycle as reaching TIMEOUT wins (normal result, err=0).
- Not defined: no counter; WAIT holds indefinitely; err and gcd_abort tied 0.

## Test plan
- Single request: req[1]=1, a=48, b=18, engine model returns 6 after 10 cycles -> gnt[1] at T+1, gcd_start one pulse, rsp_valid[1] with result=6, busy low afterward.
- Round-robin: req=4'b1111 held/refreshed, all operands (12,8) -> grants in order 0,1,2,3,0; each rsp_valid matches its gnt index, result=4.
- Zero bypass: req[2], a=0, b=35 -> no gcd_start, rsp_valid[2] at T+2, result=35; a=0,b=0 -> result=0.
- Contention after pointer: ptr=3 (after serving 2), req=4'b0101 -> gnt[0] before gnt[2].
- Reset mid-WAIT: rst_n low 1 cycle during WAIT -> all outputs 0 immediately, later gcd_done ignored, next req[0] granted first.
- Timeout (GCD_ARB_TIMEOUT_EN, TIMEOUT=20): engine never asserts done -> gcd_abort pulse after 20 WAIT cycles, rsp_valid with result=0, err=1; without macro, busy stays high.
